// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Definitions shared by the UART receiver and transmitter:
//               the receiver FSM state encoding, the data-bit count and the
//               default bit period for a 100 MHz clock at 115200 baud.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Data bits per frame (8N1).
  localparam int UART_DATA_BITS = 8;

  // 100 MHz / 115200 baud.
  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_rx_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous show-ahead FIFO holding received bytes. The head
//               entry is always presented on `head`. A push while full is
//               accepted only when a pop happens in the same cycle.
// Parameters  : DEPTH - number of entries, power of two, >= 2
//               WIDTH - entry width in bits
// Ports       : clk, reset (sync, active-high)
//               push, din   - write request and data
//               pop         - read request (ignored when empty)
//               full, empty - occupancy flags
//               head        - oldest entry (zero after reset)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    // A simultaneous pop frees the slot the push needs.
    do_push  = push && (!full || do_pop);

    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Memory is cleared so the show-ahead head reads zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : uart_rx_fifo

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 LSB-first asynchronous serial receiver. Synchronises the
//               line, validates the start bit at mid-bit, samples each data
//               bit and the stop bit at mid-bit, and delivers bytes through a
//               valid/ready handshake.
// Build macro : UART_RX_FIFO_EN - when defined, bytes are buffered in a
//               FIFO_DEPTH-entry FIFO; otherwise a single holding register.
// Parameters  : CLKS_PER_BIT - clock cycles per bit, >= 4
//               FIFO_DEPTH   - FIFO entries (power of two), FIFO build only
// Ports       : clk, reset     - clock, synchronous active-high reset
//               rx_serial      - asynchronous line input, idles high
//               rx_data[7:0]   - received byte, valid while rx_valid
//               rx_valid       - byte available
//               rx_ready       - consumer accepts (transfer on valid&ready)
//               busy           - FSM is not idle
//               frame_err      - one-cycle pulse, stop bit sampled low
//               overrun        - one-cycle pulse, completed byte dropped
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int              IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  uart_rx_state_e                state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]              bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]     shift_q, shift_d;
  logic                          sync1_q, sync1_d;
  logic                          sync2_q, sync2_d;
  logic                          frame_err_q, frame_err_d;
  logic                          overrun_q, overrun_d;
  logic                          push_req;
  logic                          store_full;
  logic                          pop;
  logic                          rxs;

  assign rxs       = sync2_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign pop       = rx_valid && rx_ready;

  // --------------------------------------------------------------------------
  // Line synchroniser and frame FSM
  // --------------------------------------------------------------------------
  always_comb begin
    sync1_d     = rx_serial;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // Line back high by mid-bit means a glitch, not a start bit.
          state_d   = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // Leaving at mid-stop-bit lets a following start edge be seen
          // with no idle gap between frames.
          if (rxs) begin
            push_req = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BREAK: begin
        cnt_d = '0;
        // Hold off until the line idles so a held-low line is not
        // mistaken for a new start bit.
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A completed byte is dropped only when storage is full and nothing is
  // popped this cycle.
  assign overrun_d = push_req && store_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Byte storage
  // --------------------------------------------------------------------------
`ifdef UART_RX_FIFO_EN
  logic fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (shift_q),
    .pop   (pop),
    .full  (store_full),
    .empty (fifo_empty),
    .head  (rx_data)
  );

  assign rx_valid = !fifo_empty;
`else
  logic [UART_DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                      hold_valid_q, hold_valid_d;
  // FIFO_DEPTH has no effect on the holding register; keep it referenced.
  logic                      unused_fifo_depth;

  assign unused_fifo_depth = ^FIFO_DEPTH;
  assign store_full        = hold_valid_q;
  assign rx_valid          = hold_valid_q;
  assign rx_data           = hold_data_q;

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    if (push_req && (!hold_valid_q || pop)) begin
      hold_data_d  = shift_q;
      hold_valid_d = 1'b1;
    end else if (pop) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
    end
  end
`endif

endmodule : uart_receiver

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver with CLKS_PER_BIT=8 and
//               FIFO_DEPTH=4. Frames are driven bit by bit; a monitor logs
//               accepted bytes and error pulses, and a queue-based model of
//               bounded storage gives the expected bytes and overrun counts.
//               Works with and without UART_RX_FIFO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_receiver;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       rx_serial = 1'b1;
  logic       rx_ready  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  int         fe_cnt       = 0;
  int         ov_cnt       = 0;
  int         valid_cycles = 0;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // Monitor: outputs are sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid)  valid_cycles++;
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; the line is left at the stop level afterwards.
  task automatic send_frame(input logic [7:0] b, input int stop_bits = 1,
                            input logic stop_val = 1'b1);
    rx_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      tick(CPB);
    end
    rx_serial = stop_val;
    tick(CPB * stop_bits);
  endtask

  task automatic wait_got(input int n, input string tag);
    for (int c = 0; c < 100 && got_q.size() < n; c++) tick(1);
    check(tag, got_q.size(), n);
  endtask

  // Reference model: bytes sent while the consumer stalls fill a store of
  // CAP entries in arrival order; every further byte is an overrun.
  task automatic stall_and_drain(input logic [7:0] bytes[$], input string tag);
    logic [7:0] exp_q[$];
    int         ov0;
    int         exp_ov;
    exp_q.delete();
    foreach (bytes[i]) if (exp_q.size() < CAP) exp_q.push_back(bytes[i]);
    exp_ov = (bytes.size() > CAP) ? bytes.size() - CAP : 0;
    rx_ready = 1'b0;
    got_q.delete();
    ov0 = ov_cnt;
    foreach (bytes[i]) send_frame(bytes[i]);
    tick(4);
    check({tag, "_overruns"}, ov_cnt - ov0, exp_ov);
    check({tag, "_head"}, rx_data, exp_q[0]);
    rx_ready = 1'b1;
    wait_got(exp_q.size(), {tag, "_drain"});
    tick(4);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    logic [7:0] bytes[$];
    int v0;
    int f0;
    int o0;
    int n;

    // ---------------- reset values ----------------
    tick(3);
    check("rst_rx_valid",  rx_valid,  1'b0);
    check("rst_rx_data",   rx_data,   8'h00);
    check("rst_busy",      busy,      1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun",   overrun,   1'b0);
    reset = 1'b0;
    tick(2);

    // ---------------- single byte 0x55 ----------------
    rx_ready = 1'b1;
    v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt;
    got_q.delete();
    send_frame(8'h55);
    tick(4);
    check("b55_count", got_q.size(), 1);
    if (got_q.size() > 0) check("b55_data", got_q[0], 8'h55);
    check("b55_valid_cycles", valid_cycles - v0, 1);
    check("b55_busy_after", busy, 1'b0);
    check("b55_no_errs", (fe_cnt - f0) + (ov_cnt - o0), 0);

    // ---------------- start-bit glitch ----------------
    v0 = valid_cycles; f0 = fe_cnt;
    rx_serial = 1'b0;
    tick(2);
    rx_serial = 1'b1;
    tick(2);
    check("glitch_busy_during", busy, 1'b1);
    tick(20);
    check("glitch_busy_after", busy, 1'b0);
    check("glitch_no_valid", valid_cycles - v0, 0);
    check("glitch_no_fe", fe_cnt - f0, 0);

    // ---------------- framing error with held-low stop ----------------
    v0 = valid_cycles; f0 = fe_cnt;
    send_frame(8'hA3, 3, 1'b0);
    check("fe_busy_while_low", busy, 1'b1);
    check("fe_pulses", fe_cnt - f0, 1);
    rx_serial = 1'b1;
    tick(5);
    check("fe_busy_after", busy, 1'b0);
    check("fe_no_valid", valid_cycles - v0, 0);

    // ---------------- overrun, directed 0x01..0x05 ----------------
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    stall_and_drain(bytes, "ovr_dir");

    // ---------------- overrun, random lengths and data ----------------
    for (int rep = 0; rep < 3; rep++) begin
      bytes.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
      stall_and_drain(bytes, $sformatf("ovr_rnd%0d", rep));
    end

    // ---------------- back-to-back 0x10, 0x20, 0x30 ----------------
    rx_ready = 1'b1;
    got_q.delete();
    o0 = ov_cnt;
    send_frame(8'h10);
    send_frame(8'h20);
    send_frame(8'h30);
    tick(4);
    check("b2b_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("b2b_byte0", got_q[0], 8'h10);
      check("b2b_byte1", got_q[1], 8'h20);
      check("b2b_byte2", got_q[2], 8'h30);
    end
    check("b2b_no_overrun", ov_cnt - o0, 0);

    // ---------------- random stream, consumer always ready ----------------
    bytes.delete();
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      bytes.push_back(8'($urandom));
      send_frame(bytes[i]);
      tick($urandom_range(0, 3));
    end
    tick(4);
    check("rnd_count", got_q.size(), bytes.size());
    foreach (bytes[i]) begin
      if (i < got_q.size()) check($sformatf("rnd_byte%0d", i), got_q[i], bytes[i]);
    end

    // ---------------- reset during DATA bit 3 of 0xFF ----------------
    rx_ready = 1'b0;
    send_frame(8'h77);
    tick(4);
    check("rstmid_pre_valid", rx_valid, 1'b1);
    rx_serial = 1'b0;
    tick(CPB);
    rx_serial = 1'b1;
    tick(CPB * 3 + 4);
    check("rstmid_pre_busy", busy, 1'b1);
    f0 = fe_cnt; o0 = ov_cnt;
    reset = 1'b1;
    tick(1);
    check("rstmid_rx_valid",  rx_valid,  1'b0);
    check("rstmid_rx_data",   rx_data,   8'h00);
    check("rstmid_busy",      busy,      1'b0);
    check("rstmid_frame_err", frame_err, 1'b0);
    check("rstmid_overrun",   overrun,   1'b0);
    reset = 1'b0;
    tick(3 * CPB);
    check("rstmid_no_pulses", (fe_cnt - f0) + (ov_cnt - o0), 0);
    check("rstmid_idle", busy, 1'b0);
    rx_ready = 1'b1;
    got_q.delete();
    send_frame(8'h3C);
    tick(4);
    check("post_rst_count", got_q.size(), 1);
    if (got_q.size() > 0) check("post_rst_data", got_q[0], 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_receiver

`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Asynchronous serial receiver (8N1, LSB first) that pairs with the existing UART transmitter on the same board-level link. It synchronises the `rx_serial` pin into the `clk` domain, detects and validates start bits, samples each bit at mid-bit, checks the stop bit, and delivers bytes through a valid/ready handshake. Optional byte buffering decouples the consumer from line timing.

## Interface
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200): clock cycles per bit; legal range ≥ 4.
- `FIFO_DEPTH`, default 16: entries in the receive FIFO; power of two. Used only with `UART_RX_FIFO_EN`.
- `clk  in  1`: system clock.
- `reset  in  1`: synchronous, active-high.
- `rx_serial  in  1`: asynchronous line input; idles high.
- `rx_data  out  8`: received byte; valid while `rx_valid` is high.
- `rx_valid  out  1`: byte available.
- `rx_ready  in  1`: consumer accepts; a transfer occurs when `rx_valid & rx_ready`.
- `busy  out  1`: high in any state other than IDLE.
- `frame_err  out  1`: one-cycle pulse; stop bit sampled low.
- `overrun  out  1`: one-cycle pulse; a completed byte was dropped because storage was full.

## Operation
- Input path: 2-FF synchroniser, both stages reset to 1; the FSM uses only the second stage (`rxs`).
- Counter: `cnt` counts 0..CLKS_PER_BIT-1. Bit index: `bit_idx` counts 0..7. Shift register: LSB first.
- FSM states:
  - IDLE: `cnt` is 0. On `rxs == 0`, go to START.
  - START: at `cnt == (CLKS_PER_BIT-1)/2`:
    - if `rxs == 0`: clear `cnt`, set `bit_idx` to 0, go to DATA;
    - else: glitch; go to IDLE with no output.
  - DATA: at `cnt == CLKS_PER_BIT-1`, shift in `rxs` and clear `cnt`. After bit 7, go to STOP.
  - STOP: at `cnt == CLKS_PER_BIT-1`, sample `rxs`:
    - if 1: push the byte and go to IDLE;
    - if 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs == 1`, then go to IDLE. This blocks a false restart on a held-low line or break condition.
- Push rules:
  - If storage is not full, or a pop occurs in the same cycle, the byte is stored.
  - Otherwise, pulse `overrun`. The new byte is dropped; stored bytes are untouched.
- Reset mid-operation: the FSM returns to IDLE and storage is emptied. Any partial byte is lost, and no `frame_err` or `overrun` pulse is generated.
- Reset values: `rx_data = 0`, `rx_valid = 0`, `busy = 0`, `frame_err = 0`, `overrun = 0`.

## Timing
- Pin-to-FSM latency: 2 cycles (synchroniser).
- The start bit is validated (CLKS_PER_BIT-1)/2 cycles after IDLE sees the low level.
- All later samples are spaced exactly CLKS_PER_BIT cycles apart, so they fall at mid-bit.
- `rx_valid` rises the cycle after the stop-bit sample. `rx_data` is registered and stable while `rx_valid` is high.
- The return to IDLE happens at the stop-bit midpoint, so back-to-back frames with no idle gap are received.
- `rx_valid` stays asserted until the byte is accepted. Pop-to-next-`rx_valid` is 0 cycles when storage holds further bytes; there is no bubble.

## Configuration
- `UART_RX_FIFO_EN` defined: storage is a `FIFO_DEPTH`-entry synchronous FIFO, show-ahead (`rx_data` reflects the head entry). Full means `FIFO_DEPTH` entries.
- `UART_RX_FIFO_EN` undefined: storage is a single holding register, full when `rx_valid` is high. `FIFO_DEPTH` is ignored.
- Handshake, overrun and push rules are identical in both builds.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encodings (IDLE, START, DATA, STOP, BREAK);
  - the data-bit count constant (8);
  - the default `CLKS_PER_BIT` constant, shared with the transmitter.
- Sub-module `uart_rx_fifo` (synchronous FIFO with push, pop, full, empty and head data) is instantiated only under `UART_RX_FIFO_EN`.

## Test plan
All scenarios use CLKS_PER_BIT=8 and FIFO_DEPTH=4 unless stated otherwise.
- Send 0x55 with `rx_ready=1` -> `rx_valid` high 1 cycle with `rx_data=0x55`; `busy` low afterwards; no error pulses.
- Drive `rx_serial` low for 2 cycles, then high -> START aborts to IDLE; no `rx_valid`, no `frame_err`.
- Send 0xA3 with the stop bit held low for 3 bit times -> one `frame_err` pulse, no `rx_valid`; `busy` stays high until the line returns high.
- With `rx_ready=0`, send 0x01..0x05 back-to-back:
  - FIFO build: one `overrun` pulse on the 5th byte, then 0x01..0x04 drain in order;
  - no-FIFO build: overrun on bytes 2..5, and 0x01 is retained.
- Hold `rx_ready=1` and send 0x10, 0x20, 0x30 back-to-back with no idle gap -> all three are delivered in order.
- Assert `reset` during DATA bit 3 of 0xFF -> all outputs are at reset values next cycle; a subsequent 0x3C is received correctly.
